// File: rtl/pc_unit_ras.sv
// Fetch program-counter unit: sequential, conditional branch, call/return via a
// circular return-address stack, back-end redirect, stall hold and sticky halt.
module pc_unit_ras #(
    parameter int ADDR_W = 16,
    parameter int STEP = 2,
    parameter int IMM_SHIFT = 1,
    parameter int RAS_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    localparam int CNT_W = $clog2(RAS_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              hlt,
    input  logic              branch,
    input  logic [2:0]        cond,
    input  logic              flag_z,
    input  logic              flag_n,
    input  logic              flag_v,
    input  logic              addr_src,
    input  logic [ADDR_W-1:0] imm_off,
    input  logic [ADDR_W-1:0] reg_addr,
    input  logic              call,
    input  logic              ret,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus,
    output logic              taken,
    output logic              halted,
    output logic [CNT_W-1:0]  ras_count,
    output logic              ras_overflow,
    output logic              ras_underflow
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(RAS_DEPTH);

    typedef enum logic [2:0] {
        ACT_HOLD,
        ACT_SEQ,
        ACT_REDIRECT,
        ACT_HALT,
        ACT_SWAP,
        ACT_POP,
        ACT_PUSH,
        ACT_BRANCH
    } action_t;

    action_t           act;
    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  top_idx;
    logic [CNT_W-1:0]  cnt;
    logic              ras_empty;
    logic              ras_full;
    logic [ADDR_W-1:0] rel_tgt;
    logic [ADDR_W-1:0] tgt;
    logic              cond_eval;
    logic              cond_ok;
    logic              wr_en;
    logic [PTR_W-1:0]  wr_idx;

    assign pc_plus   = pc + ADDR_W'(STEP);
    assign rel_tgt   = pc_plus + (imm_off << IMM_SHIFT);
    assign tgt       = addr_src ? rel_tgt : reg_addr;
    assign top_idx   = ptr - PTR_W'(1);
    assign ras_empty = (cnt == '0);
    assign ras_full  = (cnt == FULL);
    assign ras_count = cnt;

    always_comb begin
        cond_eval = 1'b0;
        case (cond)
            3'b000:  cond_eval = ~flag_z;
            3'b001:  cond_eval = flag_z;
            3'b010:  cond_eval = ~flag_z & ~flag_n;
            3'b011:  cond_eval = flag_n;
            3'b100:  cond_eval = ~flag_n;
            3'b101:  cond_eval = flag_n | flag_z;
            3'b110:  cond_eval = flag_v;
            default: cond_eval = 1'b1;
        endcase
    end

    assign cond_ok = branch & cond_eval;

    // Priority chain; a swap or pop on an empty stack falls through to pc_plus.
    always_comb begin
        act = ACT_HOLD;
        if (rst || halted)       act = ACT_HOLD;
        else if (redirect_valid) act = ACT_REDIRECT;
        else if (hlt)            act = ACT_HALT;
        else if (stall)          act = ACT_HOLD;
        else if (ret && call)    act = ACT_SWAP;
        else if (ret)            act = ACT_POP;
        else if (call)           act = ACT_PUSH;
        else if (cond_ok)        act = ACT_BRANCH;
        else                     act = ACT_SEQ;
    end

    always_comb begin
        taken = 1'b0;
        case (act)
            ACT_REDIRECT, ACT_PUSH, ACT_BRANCH: taken = 1'b1;
            ACT_SWAP, ACT_POP:                  taken = ~ras_empty;
            default:                            taken = 1'b0;
        endcase
    end

    // A swap writes in place at the top unless the stack is empty, then it pushes.
    always_comb begin
        wr_en  = 1'b0;
        wr_idx = ptr;
        if (act == ACT_PUSH) begin
            wr_en = 1'b1;
        end else if (act == ACT_SWAP) begin
            wr_en  = 1'b1;
            wr_idx = ras_empty ? ptr : top_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            ras_mem[wr_idx] <= pc_plus;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc            <= RESET_PC;
            halted        <= 1'b0;
            cnt           <= '0;
            ptr           <= '0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
        end else begin
            case (act)
                ACT_REDIRECT: pc <= redirect_addr;
                ACT_HALT:     halted <= 1'b1;
                ACT_SWAP: begin
                    if (ras_empty) begin
                        ras_underflow <= 1'b1;
                        ptr           <= ptr + PTR_W'(1);
                        cnt           <= CNT_W'(1);
                        pc            <= pc_plus;
                    end else begin
                        pc <= ras_mem[top_idx];
                    end
                end
                ACT_POP: begin
                    if (ras_empty) begin
                        ras_underflow <= 1'b1;
                        pc            <= pc_plus;
                    end else begin
                        pc  <= ras_mem[top_idx];
                        ptr <= top_idx;
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ACT_PUSH: begin
                    ptr <= ptr + PTR_W'(1);
                    if (ras_full)
                        ras_overflow <= 1'b1;
                    else
                        cnt <= cnt + CNT_W'(1);
                    pc <= tgt;
                end
                ACT_BRANCH: pc <= tgt;
                ACT_SEQ:    pc <= pc_plus;
                default:    ;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_unit_ras.sv
// Scoreboard bench for pc_unit_ras: directed scenarios plus random traffic,
// checked against a queue-based reference model.
module tb_pc_unit_ras;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        hlt = 1'b0;
    logic        branch = 1'b0;
    logic [2:0]  cond = 3'b0;
    logic        flag_z = 1'b0;
    logic        flag_n = 1'b0;
    logic        flag_v = 1'b0;
    logic        addr_src = 1'b0;
    logic [15:0] imm_off = 16'h0;
    logic [15:0] reg_addr = 16'h0;
    logic        call = 1'b0;
    logic        ret = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_addr = 16'h0;
    logic [15:0] pc;
    logic [15:0] pc_plus;
    logic        taken;
    logic        halted;
    logic [2:0]  ras_count;
    logic        ras_overflow;
    logic        ras_underflow;

    int checks = 0;
    int errors = 0;

    pc_unit_ras dut (
        .clk(clk), .rst(rst), .stall(stall), .hlt(hlt), .branch(branch),
        .cond(cond), .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v),
        .addr_src(addr_src), .imm_off(imm_off), .reg_addr(reg_addr),
        .call(call), .ret(ret), .redirect_valid(redirect_valid),
        .redirect_addr(redirect_addr), .pc(pc), .pc_plus(pc_plus),
        .taken(taken), .halted(halted), .ras_count(ras_count),
        .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst, stall, hlt, branch;
        logic [2:0]  cond;
        logic        z, n, v, addr_src;
        logic [15:0] imm_off, reg_addr;
        logic        call, ret, redirect_valid;
        logic [15:0] redirect_addr;
    } stim_t;

    typedef struct {
        logic        chk_plus;
        logic [15:0] pc_plus;
        logic        taken;
        logic [15:0] pc;
        logic        halted;
        logic [2:0]  count;
        logic        ovf, unf;
    } exp_t;

    exp_t sb[$];

    // Reference state: the stack is a plain queue whose back is the top entry.
    logic [15:0] m_pc = 16'h0;
    bit          m_known = 1'b0;
    bit          m_halted = 1'b0;
    bit          m_ovf = 1'b0;
    bit          m_unf = 1'b0;
    logic [15:0] m_ras[$];

    function automatic bit condHolds(logic [2:0] c, bit z, bit n, bit v);
        case (c)
            3'd0:    return !z;
            3'd1:    return z;
            3'd2:    return !z && !n;
            3'd3:    return n;
            3'd4:    return !n;
            3'd5:    return n || z;
            3'd6:    return v;
            default: return 1'b1;
        endcase
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input stim_t s);
        exp_t        e;
        logic [15:0] pp;
        logic [15:0] tgt;
        logic [15:0] shifted;
        @(posedge clk);
        #1;
        rst = s.rst; stall = s.stall; hlt = s.hlt; branch = s.branch;
        cond = s.cond; flag_z = s.z; flag_n = s.n; flag_v = s.v;
        addr_src = s.addr_src; imm_off = s.imm_off; reg_addr = s.reg_addr;
        call = s.call; ret = s.ret; redirect_valid = s.redirect_valid;
        redirect_addr = s.redirect_addr;

        pp      = m_pc + 16'd2;
        shifted = s.imm_off << 1;
        tgt     = s.addr_src ? pp + shifted : s.reg_addr;
        e.chk_plus = m_known;
        e.pc_plus  = pp;
        e.taken    = 1'b0;
        if (s.rst) begin
            m_pc = 16'h0; m_halted = 0; m_ovf = 0; m_unf = 0; m_known = 1;
            m_ras.delete();
        end else if (m_halted) begin
        end else if (s.redirect_valid) begin
            m_pc = s.redirect_addr; e.taken = 1'b1;
        end else if (s.hlt) begin
            m_halted = 1;
        end else if (s.stall) begin
        end else if (s.ret && s.call) begin
            if (m_ras.size() > 0) begin
                e.taken = 1'b1;
                m_pc = m_ras[$];
                m_ras[m_ras.size()-1] = pp;
            end else begin
                m_unf = 1;
                m_ras.push_back(pp);
                m_pc = pp;
            end
        end else if (s.ret) begin
            if (m_ras.size() > 0) begin
                e.taken = 1'b1;
                m_pc = m_ras.pop_back();
            end else begin
                m_unf = 1;
                m_pc = pp;
            end
        end else if (s.call) begin
            if (m_ras.size() == 4) begin
                void'(m_ras.pop_front());
                m_ovf = 1;
            end
            m_ras.push_back(pp);
            m_pc = tgt; e.taken = 1'b1;
        end else if (condHolds(s.cond, s.z, s.n, s.v) && s.branch) begin
            m_pc = tgt; e.taken = 1'b1;
        end else begin
            m_pc = pp;
        end
        e.pc     = m_pc;
        e.halted = m_halted;
        e.count  = 3'(m_ras.size());
        e.ovf    = m_ovf;
        e.unf    = m_unf;
        sb.push_back(e);
    endtask

    // Monitor: combinational outputs mid-cycle, registered outputs after the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput("taken", 16'(taken), 16'(e.taken));
                if (e.chk_plus)
                    checkOutput("pc_plus", pc_plus, e.pc_plus);
                @(posedge clk);
                #2;
                checkOutput("pc", pc, e.pc);
                checkOutput("halted", 16'(halted), 16'(e.halted));
                checkOutput("ras_count", 16'(ras_count), 16'(e.count));
                checkOutput("ras_overflow", 16'(ras_overflow), 16'(e.ovf));
                checkOutput("ras_underflow", 16'(ras_underflow), 16'(e.unf));
            end
        end
    end

    task automatic redirectTo(input logic [15:0] a, input bit with_hlt);
        stim_t s;
        s = idle();
        s.redirect_valid = 1'b1;
        s.redirect_addr = a;
        s.hlt = with_hlt;
        applyStimulus(s);
    endtask

    task automatic callReg(input logic [15:0] a, input bit with_ret);
        stim_t s;
        s = idle();
        s.call = 1'b1;
        s.ret = with_ret;
        s.reg_addr = a;
        applyStimulus(s);
    endtask

    task automatic doRet();
        stim_t s;
        s = idle();
        s.ret = 1'b1;
        applyStimulus(s);
    endtask

    initial begin
        stim_t s;

        s = idle(); s.rst = 1'b1;
        applyStimulus(s);
        repeat (3) applyStimulus(idle());

        for (int zv = 1; zv >= 0; zv--) begin
            redirectTo(16'h0010, 1'b0);
            s = idle();
            s.branch = 1'b1; s.cond = 3'b001; s.z = 1'(zv);
            s.addr_src = 1'b1; s.imm_off = 16'hFFFC;
            applyStimulus(s);
        end

        redirectTo(16'h0100, 1'b0);
        for (int i = 2; i <= 6; i++) callReg(16'(i * 16'h0100), 1'b0);
        repeat (5) doRet();

        redirectTo(16'h0120, 1'b0);
        callReg(16'h0040, 1'b0);
        callReg(16'h0777, 1'b1);
        doRet();
        callReg(16'h0300, 1'b1);

        s = idle(); s.stall = 1'b1; s.branch = 1'b1; s.cond = 3'b111; s.reg_addr = 16'h0ABC;
        applyStimulus(s);
        s = idle(); s.hlt = 1'b1;
        applyStimulus(s);
        redirectTo(16'h0500, 1'b0);
        applyStimulus(idle());
        s = idle(); s.rst = 1'b1;
        applyStimulus(s);

        redirectTo(16'hFFFE, 1'b0);
        applyStimulus(idle());
        redirectTo(16'h1234, 1'b1);
        applyStimulus(idle());

        for (int i = 0; i < 2000; i++) begin
            s = idle();
            s.rst            = ($urandom_range(0, 63) == 0);
            s.stall          = ($urandom_range(0, 7) == 0);
            s.hlt            = ($urandom_range(0, 119) == 0);
            s.redirect_valid = ($urandom_range(0, 15) == 0);
            s.call           = ($urandom_range(0, 4) == 0);
            s.ret            = ($urandom_range(0, 3) == 0);
            s.branch         = 1'($urandom);
            s.cond           = 3'($urandom);
            s.z              = 1'($urandom);
            s.n              = 1'($urandom);
            s.v              = 1'($urandom);
            s.addr_src       = 1'($urandom);
            s.imm_off        = 16'($urandom);
            s.reg_addr       = 16'($urandom);
            s.redirect_addr  = 16'($urandom);
            applyStimulus(s);
        end

        repeat (4) @(posedge clk);
        #3;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
